// File: rtl/dm_access_ctrl.sv
// Purpose : MEM-stage initiator controller for a word-wide data memory.
//           Handles byte/half/word loads (extract + extend) and stores
//           (read-modify-write for sub-word), and flags misaligned requests.
// Latency : accept -> resp_valid: load 2, word store 2, sub-word store 3,
//           misaligned 1.
// Backpr. : one request in flight; req_ready is high only in IDLE.
// Ports   : clk/reset (async active-low); req_* pipeline request side;
//           resp_* single-cycle completion; mem_* word-aligned memory side
//           (mem_RD is combinational read data for mem_A).
module dm_access_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_type,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic [31:0] mem_A,
  output logic [31:0] mem_WD,
  output logic        mem_WE,
  output logic [31:0] mem_PC,
  input  logic [31:0] mem_RD
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [2:0] T_HALF_S = 3'd1;
  localparam logic [2:0] T_HALF_U = 3'd2;
  localparam logic [2:0] T_BYTE_S = 3'd3;
  localparam logic [2:0] T_BYTE_U = 3'd4;

  logic [1:0]  state_q,  state_d;
  logic        we_q,     we_d;
  logic [2:0]  type_q,   type_d;
  logic [1:0]  off_q,    off_d;     // byte offset within the word
  logic [15:0] wdata_q,  wdata_d;   // only the low half is ever merged
  logic [31:0] pc_q,     pc_d;
  logic        err_q,    err_d;
  logic [31:0] rdata_q,  rdata_d;
  logic [31:0] mem_a_q,  mem_a_d;
  logic [31:0] mem_wd_q, mem_wd_d;

  logic req_half, req_byte, req_word, req_misaligned;

  // Pick the addressed lane out of the read word and extend it.
  function automatic logic [31:0] load_extract(input logic [31:0] w,
                                               input logic [2:0]  t,
                                               input logic [1:0]  off);
    logic [31:0] sh;
    logic [15:0] h;
    logic [31:0] r;
    sh = w >> {off, 3'b000};
    h  = off[1] ? w[31:16] : w[15:0];
    case (t)
      T_HALF_S: r = {{16{h[15]}}, h};
      T_HALF_U: r = {16'h0000, h};
      T_BYTE_S: r = {{24{sh[7]}}, sh[7:0]};
      T_BYTE_U: r = {24'h000000, sh[7:0]};
      default:  r = w;
    endcase
    return r;
  endfunction

  // Replace only the addressed lane of the read word with store data.
  function automatic logic [31:0] store_merge(input logic [31:0] w,
                                              input logic [15:0] d,
                                              input logic [2:0]  t,
                                              input logic [1:0]  off);
    logic [31:0] r;
    r = w;
    case (t)
      T_HALF_S, T_HALF_U: begin
        if (off[1]) r[31:16] = d;
        else        r[15:0]  = d;
      end
      T_BYTE_S, T_BYTE_U: begin
        case (off)
          2'd0:    r[7:0]   = d[7:0];
          2'd1:    r[15:8]  = d[7:0];
          2'd2:    r[23:16] = d[7:0];
          default: r[31:24] = d[7:0];
        endcase
      end
      default: r = w;
    endcase
    return r;
  endfunction

  // Types 5-7 fall through to word handling.
  assign req_half       = (req_type == T_HALF_S) || (req_type == T_HALF_U);
  assign req_byte       = (req_type == T_BYTE_S) || (req_type == T_BYTE_U);
  assign req_word       = !req_half && !req_byte;
  assign req_misaligned = (req_half && req_addr[0]) ||
                          (req_word && (req_addr[1:0] != 2'b00));

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    type_d   = type_q;
    off_d    = off_q;
    wdata_d  = wdata_q;
    pc_d     = pc_q;
    err_d    = err_q;
    rdata_d  = rdata_q;
    mem_a_d  = mem_a_q;
    mem_wd_d = mem_wd_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          type_d  = req_type;
          off_d   = req_addr[1:0];
          wdata_d = req_wdata[15:0];
          pc_d    = req_pc;
          rdata_d = 32'h0;
          err_d   = 1'b0;
          if (req_misaligned) begin
            // Memory-side address/data are left untouched on errors.
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            mem_a_d = {req_addr[31:2], 2'b00};
            if (req_we && req_word) begin
              mem_wd_d = req_wdata;
              state_d  = S_WR;
            end else begin
              state_d = S_RD;
            end
          end
        end
      end
      S_RD: begin
        if (!we_q) begin
          rdata_d = load_extract(mem_RD, type_q, off_q);
          state_d = S_DONE;
        end else begin
          mem_wd_d = store_merge(mem_RD, wdata_q, type_q, off_q);
          state_d  = S_WR;
        end
      end
      S_WR:    state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      we_q     <= 1'b0;
      type_q   <= 3'd0;
      off_q    <= 2'd0;
      wdata_q  <= 16'h0;
      pc_q     <= 32'h0;
      err_q    <= 1'b0;
      rdata_q  <= 32'h0;
      mem_a_q  <= 32'h0;
      mem_wd_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      type_q   <= type_d;
      off_q    <= off_d;
      wdata_q  <= wdata_d;
      pc_q     <= pc_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      mem_a_q  <= mem_a_d;
      mem_wd_q <= mem_wd_d;
    end
  end

  // Pure state decode: reset pulls mem_WE low without waiting for an edge.
  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_DONE);
  assign resp_err   = resp_valid && err_q;
  assign resp_rdata = resp_valid ? rdata_q : 32'h0;
  assign mem_WE     = (state_q == S_WR);
  assign mem_A      = mem_a_q;
  assign mem_WD     = mem_wd_q;
  assign mem_PC     = pc_q;

endmodule

// File: doc/dm_access_ctrl.md
# dm_access_ctrl

Initiator-side controller that sits between the MEM pipeline stage and the word-wide data memory. Accepts one load/store request at a time with byte, halfword or word granularity. Drives word-aligned memory accesses, performing read-modify-write for sub-word stores and extract/extend for sub-word loads. Returns a single-cycle response to the pipeline and flags misaligned requests without touching memory.

## Interface
- No parameters. Data/address width fixed at 32; memory word-addressed via address bits [31:2].
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: asynchronous, active-low. Low forces the reset state immediately.
- `req_valid` in 1: request present.
- `req_ready` out 1: controller can accept a request (high only in IDLE).
- `req_we` in 1: 1 = store, 0 = load.
- `req_type` in 3: 0 word, 1 half signed, 2 half unsigned, 3 byte signed, 4 byte unsigned; 5–7 treated as word.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data; sub-word stores use low bits.
- `req_pc` in 32: PC of the instruction, forwarded to memory.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_err` out 1: misaligned request, valid with `resp_valid`.
- `resp_rdata` out 32: load result, valid with `resp_valid`; 0 for stores and errors.
- `mem_A` out 32: word-aligned address `{addr[31:2],2'b00}`.
- `mem_WD` out 32: full write word.
- `mem_WE` out 1: write enable; memory writes on the rising edge while high.
- `mem_PC` out 32: latched `req_pc`.
- `mem_RD` in 32: combinational read data for `mem_A`.

## Operation
- Moore FSM with states IDLE, RD, WR, DONE. All memory-side and response outputs decode from the state register and latched request registers only.
- IDLE
  - `req_ready`=1.
  - On `req_valid`: latch `we`, `type`, `addr`, `wdata`, `pc`.
  - Misaligned goes to DONE with error set. Misaligned means a half with addr[0]=1, or a word with addr[1:0]≠0.
  - Otherwise, a load or a sub-word store goes to RD.
  - Otherwise, a word store goes to WR.
- RD
  - `mem_WE`=0; capture `mem_RD` into the data register.
  - Load: compute the result, then go to DONE.
  - Sub-word store: merge `wdata` into the captured word, then go to WR.
- WR
  - `mem_WE`=1 for exactly this cycle, with `mem_WD` = merged word (or `wdata` for a word store).
  - Then go to DONE.
- DONE: `resp_valid`=1, then go to IDLE. Any new request is accepted no earlier than the following cycle.
- Byte lanes are little-endian.
  - Byte k = addr[1:0] occupies bits [8k+7:8k].
  - Half h = addr[1] occupies bits [16h+15:16h].
- Load extension: signed types sign-extend from the lane MSB; unsigned types zero-extend; word is passed through.
- Sub-word store merge: replace only the selected lane with `wdata[7:0]` or `wdata[15:0]`; other lanes keep the value read in RD.
- Errors:
  - No memory cycle; `mem_WE` never asserted.
  - `resp_err`=1, `resp_rdata`=0.
- Outside RD and WR, `mem_A` and `mem_WD` hold their last values; `mem_WE`=0.

## Timing
- Reset (asynchronous, low):
  - Forces state=IDLE and clears all latched registers.
  - Outputs: `req_ready`=1, `resp_valid`=0, `resp_err`=0, `resp_rdata`=0, `mem_WE`=0, `mem_A`=0, `mem_WD`=0, `mem_PC`=0.
- Reset mid-operation:
  - Request is dropped; no response is issued.
  - If asserted during WR, `mem_WE` falls immediately, so no write happens at the next edge.
- Latency from the accepting edge to the `resp_valid` cycle:
  - Load: 2 cycles (RD, DONE).
  - Word store: 2 cycles (WR, DONE).
  - Sub-word store: 3 cycles (RD, WR, DONE).
  - Misaligned: 1 cycle (DONE).
- Throughput: at most one request in flight. `req_ready` is low from RD/WR/DONE until IDLE is re-entered.
- `req_*` inputs are ignored except on the accepting edge. Changes to them after acceptance do not affect the operation.

## Test plan
- Reset low mid-WR, with a sub-word store at 0x20 in progress → `mem_WE` drops immediately; word 0x20 is unchanged; no `resp_valid`; `req_ready`=1 while in reset.
- Word store 0x12345678 to 0x00000010, then word load from 0x10 → memory written on exactly one edge with `mem_A`=0x10; `resp_valid` 2 cycles after each accept; load returns 0x12345678.
- Memory word 0x80FF7F01 at 0x20; loads of type 3/4 at 0x22, type 1/2 at 0x22, and type 3 at 0x21 → 0x00000001... corrected per lane:
  - byte@0x22 signed = 0xFFFFFFFF, unsigned = 0x000000FF;
  - half@0x22 signed = 0xFFFF80FF, unsigned = 0x000080FF;
  - byte@0x21 signed = 0x0000007F.
- Byte store 0xAB to 0x23, then half store 0xCDEF to 0x20, over initial 0x11223344 → sequence RD, WR, DONE for each; final word 0xAB22CDEF; each `resp_valid` 3 cycles after accept.
- Half load at 0x31 and word store at 0x32 → `resp_err`=1, `resp_rdata`=0 one cycle after accept; `mem_WE` never high; memory unchanged.
- Back-to-back `req_valid` held high → `req_ready` low during RD/WR/DONE; second request accepted only when IDLE is re-entered; `mem_PC` matches each request's `req_pc` during its WR.
